// File: rtl/mat_mul_seq.sv
// Sequential matrix-multiply sequencer: streams row/column vector pairs to an
// external dot-product unit and scatters the returned results into C = A * B.
module mat_mul_seq #(
   parameter int EXP_WIDTH   = 8,
   parameter int MAN_WIDTH   = 23,
   parameter int BIAS        = -127,
   parameter int VEC_SIZE    = 4,
   parameter int ROWS        = 2,
   parameter int COLS        = 2,
   parameter int DOT_LATENCY = 3,
   localparam int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [ROWS*VEC_SIZE*FLOAT_WIDTH-1:0]  lhs,
   input  logic [COLS*VEC_SIZE*FLOAT_WIDTH-1:0]  rhs,
   output logic [VEC_SIZE*FLOAT_WIDTH-1:0]       dot_lhs,
   output logic [VEC_SIZE*FLOAT_WIDTH-1:0]       dot_rhs,
   input  logic [FLOAT_WIDTH-1:0]                dot_out,
   output logic [ROWS*COLS*FLOAT_WIDTH-1:0]      result,
   output logic                                  busy,
   output logic                                  done
);

   localparam int VW  = VEC_SIZE * FLOAT_WIDTH;
   localparam int N   = ROWS * COLS;
   localparam int K_W = (N > 1) ? $clog2(N) : 1;
   localparam int I_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int J_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);
   localparam logic [J_W-1:0] J_LAST = J_W'(COLS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [K_W-1:0]          r_k;
   logic [I_W-1:0]          r_i;
   logic [J_W-1:0]          r_j;
   logic [I_W-1:0]          w_i_nxt;
   logic [J_W-1:0]          w_j_nxt;
   logic [ROWS*VW-1:0]      r_lhs_lat;
   logic [COLS*VW-1:0]      r_rhs_lat;
   logic [VW-1:0]           r_dot_lhs;
   logic [VW-1:0]           r_dot_rhs;
   logic [DOT_LATENCY-1:0]  r_tag_vld;
   logic [K_W-1:0]          r_tag_k [DOT_LATENCY];
   logic [N*FLOAT_WIDTH-1:0] r_result;
   logic                    w_last_wr;

   assign w_last_wr = r_tag_vld[DOT_LATENCY-1] && (r_tag_k[DOT_LATENCY-1] == K_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_ISSUE;
         S_ISSUE: if (r_k == K_LAST) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_last_wr) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_ISSUE) || (r_state == S_DRAIN);
      done = (r_state == S_DONE);
   end

   // Row-major walk: column index wraps first, then the row advances.
   always_comb begin
      w_i_nxt = r_i;
      w_j_nxt = r_j + J_W'(1);
      if (r_j == J_LAST) begin
         w_j_nxt = '0;
         w_i_nxt = r_i + I_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k       <= '0;
         r_i       <= '0;
         r_j       <= '0;
         r_lhs_lat <= '0;
         r_rhs_lat <= '0;
         r_dot_lhs <= '0;
         r_dot_rhs <= '0;
         r_tag_vld <= '0;
         for (int s = 0; s < DOT_LATENCY; s++) r_tag_k[s] <= '0;
         r_result  <= '0;
      end else begin
         // Pair 0 comes straight from the inputs so it is on the bus in the first ISSUE cycle.
         if (r_state == S_IDLE && start) begin
            r_lhs_lat <= lhs;
            r_rhs_lat <= rhs;
            r_k       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_dot_lhs <= lhs[VW-1:0];
            r_dot_rhs <= rhs[VW-1:0];
         end else if (r_state == S_ISSUE && r_k != K_LAST) begin
            r_k       <= r_k + K_W'(1);
            r_i       <= w_i_nxt;
            r_j       <= w_j_nxt;
            r_dot_lhs <= r_lhs_lat[int'(w_i_nxt)*VW +: VW];
            r_dot_rhs <= r_rhs_lat[int'(w_j_nxt)*VW +: VW];
         end
         r_tag_vld[0] <= (r_state == S_ISSUE);
         r_tag_k[0]   <= r_k;
         for (int s = 1; s < DOT_LATENCY; s++) begin
            r_tag_vld[s] <= r_tag_vld[s-1];
            r_tag_k[s]   <= r_tag_k[s-1];
         end
         if (r_tag_vld[DOT_LATENCY-1])
            r_result[int'(r_tag_k[DOT_LATENCY-1])*FLOAT_WIDTH +: FLOAT_WIDTH] <= dot_out;
      end
   end

   assign dot_lhs = r_dot_lhs;
   assign dot_rhs = r_dot_rhs;
   assign result  = r_result;

endmodule

// File: tb/tb_mat_mul_seq.sv
// Directed bench for mat_mul_seq with a fixed-latency vec_dot stand-in and a
// result scoreboard; covers 2x2 and 1x1 configurations.
module tb_mat_mul_seq;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          start1 = 1'b0;
   logic [127:0]  lhs = '0;
   logic [127:0]  rhs = '0;
   logic [63:0]   dot_lhs, dot_rhs;
   logic [31:0]   dot_out;
   logic [127:0]  result;
   logic          busy, done;
   logic [63:0]   lhs1 = '0;
   logic [63:0]   rhs1 = '0;
   logic [63:0]   dot_lhs1, dot_rhs1;
   logic [31:0]   dot_out1;
   logic [31:0]   result1;
   logic          busy1, done1;

   int            n_tests = 0;
   int            n_fail = 0;
   logic [127:0]  sb_q[$];
   logic [127:0]  sb1_q[$];

   always #5 clk = ~clk;

   mat_mul_seq #(.EXP_WIDTH(8), .MAN_WIDTH(23), .BIAS(-127), .VEC_SIZE(2),
                 .ROWS(2), .COLS(2), .DOT_LATENCY(3)) u_dut (
      .clk(clk), .rst(rst), .start(start), .lhs(lhs), .rhs(rhs),
      .dot_lhs(dot_lhs), .dot_rhs(dot_rhs), .dot_out(dot_out),
      .result(result), .busy(busy), .done(done));

   mat_mul_seq #(.EXP_WIDTH(8), .MAN_WIDTH(23), .BIAS(-127), .VEC_SIZE(2),
                 .ROWS(1), .COLS(1), .DOT_LATENCY(3)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .lhs(lhs1), .rhs(rhs1),
      .dot_lhs(dot_lhs1), .dot_rhs(dot_rhs1), .dot_out(dot_out1),
      .result(result1), .busy(busy1), .done(done1));

   // Stand-in element "product": exact for 0 and 1.0 operands, otherwise an
   // operand-sensitive bit mix so misrouted vectors show up.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h0 || b == 32'h0) return 32'h0;
      if (a == 32'h3F800000) return b;
      if (b == 32'h3F800000) return a;
      return a ^ {b[15:0], b[31:16]};
   endfunction

   function automatic logic [31:0] fdot(input logic [63:0] a, input logic [63:0] b);
      return fmul(a[31:0], b[31:0]) ^ fmul(a[63:32], b[63:32]);
   endfunction

   function automatic logic [127:0] exp_mat(input logic [127:0] l, input logic [127:0] r);
      logic [127:0] e;
      e = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            e[(i*2+j)*32 +: 32] = fdot(l[i*64 +: 64], r[j*64 +: 64]);
      return e;
   endfunction

   logic [31:0] m_p0 = '0, m_p1 = '0, m_p2 = '0;
   logic [31:0] m1_p0 = '0, m1_p1 = '0, m1_p2 = '0;
   always @(posedge clk) begin
      m_p0  <= fdot(dot_lhs, dot_rhs);
      m_p1  <= m_p0;
      m_p2  <= m_p1;
      m1_p0 <= fdot(dot_lhs1, dot_rhs1);
      m1_p1 <= m1_p0;
      m1_p2 <= m1_p1;
   end
   assign dot_out  = m_p2;
   assign dot_out1 = m1_p2;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_compare(input string tag);
      if (sb_q.size() == 0) check({tag, "_unexpected_done"}, 128'(done), 128'(0));
      else check(tag, result, sb_q.pop_front());
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) lat = c;
      end
      check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_result", result, 128'(0));
      check("rst_dot_lhs", 128'(dot_lhs), 128'(0));
      check("rst_dot_rhs", 128'(dot_rhs), 128'(0));
      check("rst_busy1", 128'(busy1), 128'(0));

      // Identity times 2I, with input churn and ignored starts, then a back-to-back run.
      lhs   = {32'h3F800000, 32'h0, 32'h0, 32'h3F800000};
      rhs   = {32'h40000000, 32'h0, 32'h0, 32'h40000000};
      rst   = 1'b0;
      start = 1'b1;
      sb_q.push_back(exp_mat(lhs, rhs));
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         check("A_busy", 128'(busy), 128'((c <= 7) || (c >= 10 && c <= 16)));
         check("A_done", 128'(done), 128'(c == 8 || c == 17));
         if (c == 1) begin
            check("A_dot_lhs_p0", 128'(dot_lhs), 128'(64'h00000000_3F800000));
            check("A_dot_rhs_p0", 128'(dot_rhs), 128'(64'h00000000_40000000));
         end
         if (c == 2) check("A_dot_rhs_p1", 128'(dot_rhs), 128'(64'h40000000_00000000));
         if (c == 3) check("A_dot_lhs_p2", 128'(dot_lhs), 128'(64'h3F800000_00000000));
         if (done) pop_compare("A_result");
         if (c == 8) check("A_ident", result, {32'h40000000, 64'h0, 32'h40000000});
         if (c == 2) begin
            lhs = {$urandom, $urandom, $urandom, $urandom};
            rhs = {$urandom, $urandom, $urandom, $urandom};
         end
         if (c == 9) sb_q.push_back(exp_mat(lhs, rhs));
         start = (c == 3 || c == 8 || c == 9);
      end
      check("A_sb_empty", 128'(sb_q.size()), 128'(0));

      // Reset in the middle of an operation.
      @(negedge clk);
      lhs   = {32'h3F800000, 32'h0, 32'h0, 32'h3F800000};
      rhs   = {32'h40000000, 32'h0, 32'h0, 32'h40000000};
      start = 1'b1;
      sb_q.push_back(exp_mat(lhs, rhs));
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst = 1'b1;
      sb_q.delete();
      #1;
      check("B_rst_busy", 128'(busy), 128'(0));
      check("B_rst_done", 128'(done), 128'(0));
      check("B_rst_result", result, 128'(0));
      check("B_rst_dot_lhs", 128'(dot_lhs), 128'(0));
      check("B_rst_dot_rhs", 128'(dot_rhs), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         check("B_no_done", 128'(done), 128'(0));
         check("B_no_write", result, 128'(0));
      end

      // NaN passes through bit-exact after reset recovery.
      lhs   = {32'h3F800000, 32'h0, 32'h0, 32'h7FC00000};
      rhs   = {32'h40000000, 32'h0, 32'h0, 32'h3F800000};
      start = 1'b1;
      sb_q.push_back(exp_mat(lhs, rhs));
      wait_done("C", 8);
      pop_compare("C_result");
      check("C_nan_slot", 128'(result[31:0]), 128'(32'h7FC00000));
      check("C_full", result, {32'h40000000, 64'h0, 32'h7FC00000});
      @(negedge clk);
      check("C_done_one_cycle", 128'(done), 128'(0));

      // Single-element configuration.
      lhs1   = {$urandom, 32'h3F800000};
      rhs1   = {$urandom, $urandom};
      start1 = 1'b1;
      sb1_q.push_back(128'(fdot(lhs1, rhs1)));
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start1 = 1'b0;
         check("D_busy", 128'(busy1), 128'(c <= 4));
         check("D_done", 128'(done1), 128'(c == 5));
         if (done1) begin
            if (sb1_q.size() == 0) check("D_unexpected_done", 128'(done1), 128'(0));
            else check("D_result", 128'(result1), sb1_q.pop_front());
         end
      end
      check("D_sb_empty", 128'(sb1_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
